// File: rtl/id_stage_ctrl_if.sv
// Fetch-to-decode bus: fetched instruction and hazard inputs in,
// IF/ID register contents and pipeline control out.
interface id_stage_ctrl_if;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        branch_taken;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_valid;
  logic [2:0]  imm_type;
  logic        pc_write;
  logic        id_ex_bubble;

  modport master (
    output if_inst, if_pc, ex_mem_read, ex_rd, branch_taken,
    input  id_inst, id_pc, id_valid, imm_type, pc_write, id_ex_bubble
  );

  modport slave (
    input  if_inst, if_pc, ex_mem_read, ex_rd, branch_taken,
    output id_inst, id_pc, id_valid, imm_type, pc_write, id_ex_bubble
  );
endinterface

// File: rtl/id_stage_ctrl.sv
// IF/ID pipeline register with load-use stall, branch squash sequencing and
// registered immediate-format select for the decode stage.
module id_stage_ctrl #(
  parameter int unsigned BR_PENALTY = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_stage_ctrl_if.slave   bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;
  typedef enum logic [2:0] {
    IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4, IMM_NONE = 3'd7
  } imm_e;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      pc_q, pc_d;
  logic             valid_q, valid_d;
  imm_e             imm_q, imm_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             uses_rs1, uses_rs2, hazard;

  function automatic imm_e decode_imm(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: return IMM_I;
      OP_STORE:                 return IMM_S;
      OP_BRANCH:                return IMM_B;
      OP_LUI, OP_AUIPC:         return IMM_U;
      OP_JAL:                   return IMM_J;
      default:                  return IMM_NONE;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (inst_q[6:0])
      OP_R, OP_STORE, OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_IMM, OP_LOAD, OP_JALR:  uses_rs1 = 1'b1;
      default: ;
    endcase
    hazard = valid_q & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
             ((uses_rs1 & (bus.ex_rd == inst_q[19:15])) |
              (uses_rs2 & (bus.ex_rd == inst_q[24:20])));
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    imm_d   = imm_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (bus.branch_taken) begin
      inst_d  = NOP;
      valid_d = 1'b0;
      imm_d   = IMM_NONE;
      flush_d = sat_inc(flush_q);
      if (BR_PENALTY > 1) begin
        state_d = ST_FLUSH;
        fcnt_d  = 3'(BR_PENALTY - 1);
      end else begin
        state_d = ST_RUN;
      end
    end else if (state_q == ST_FLUSH) begin
      inst_d  = NOP;
      valid_d = 1'b0;
      imm_d   = IMM_NONE;
      flush_d = sat_inc(flush_q);
      fcnt_d  = fcnt_q - 3'd1;
      if (fcnt_q == 3'd1) state_d = ST_RUN;
    end else if (hazard) begin
      stall_d = sat_inc(stall_q);
    end else begin
      inst_d  = bus.if_inst;
      pc_d    = bus.if_pc;
      valid_d = 1'b1;
      imm_d   = decode_imm(bus.if_inst[6:0]);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      fcnt_q  <= 3'd0;
      inst_q  <= NOP;
      pc_q    <= 32'd0;
      valid_q <= 1'b0;
      imm_q   <= IMM_NONE;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      imm_q   <= imm_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.id_inst      = inst_q;
  assign bus.id_pc        = pc_q;
  assign bus.id_valid     = valid_q;
  assign bus.imm_type     = imm_q;
  assign bus.pc_write     = !hazard | bus.branch_taken;
  assign bus.id_ex_bubble = hazard | !valid_q;
  assign stall_cnt        = stall_q;
  assign flush_cnt        = flush_q;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Bench for id_stage_ctrl: directed vector table, corner sequences and a
// randomized run against a slot-counting reference model, on two configurations.
module tb_id_stage_ctrl;

  localparam int PEN_A = 2;
  localparam int PEN_B = 3;
  localparam int MAX_A = 65535;
  localparam int MAX_B = 15;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_stage_ctrl_if bus_a ();
  id_stage_ctrl_if bus_b ();
  logic [15:0] stall_a, flush_a;
  logic [3:0]  stall_b, flush_b;

  id_stage_ctrl #(.BR_PENALTY(PEN_A), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .stall_cnt(stall_a), .flush_cnt(flush_a));
  id_stage_ctrl #(.BR_PENALTY(PEN_B), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .stall_cnt(stall_b), .flush_cnt(flush_b));

  typedef struct {
    logic        rst;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        mr;
    logic [4:0]  rd;
    logic        bt;
  } in_t;

  // Reference: squash_left counts remaining wrong-path slots.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic [2:0]  imm;
    int          squash_left;
    int          stalls;
    int          flushes;
  } mdl_t;

  typedef struct {
    in_t         in;
    logic        pcw;
    logic        bub;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic [2:0]  imm;
    int          stall;
    int          flush;
  } vec_t;

  int checks = 0;
  int errors = 0;
  mdl_t ma, mb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.inst = NOP; m.pc = 32'd0; m.valid = 1'b0; m.imm = 3'd7;
    m.squash_left = 0; m.stalls = 0; m.flushes = 0;
    return m;
  endfunction

  function automatic logic [2:0] mdl_imm(input logic [6:0] op);
    if (op inside {7'b0000011, 7'b0010011, 7'b1100111}) return 3'd0;
    if (op == 7'b0100011) return 3'd1;
    if (op == 7'b1100011) return 3'd2;
    if (op inside {7'b0110111, 7'b0010111}) return 3'd3;
    if (op == 7'b1101111) return 3'd4;
    return 3'd7;
  endfunction

  function automatic logic mdl_hazard(input mdl_t m, input in_t in);
    logic r1, r2;
    r1 = m.inst[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
    r2 = m.inst[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    return m.valid && in.mr && in.rd != 0 &&
           ((r1 && in.rd == m.inst[19:15]) || (r2 && in.rd == m.inst[24:20]));
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int pen, input int cmax, input in_t in);
    mdl_t n;
    n = m;
    if (in.rst) return mdl_reset();
    if (in.bt || m.squash_left > 0) begin
      n.inst = NOP; n.valid = 1'b0; n.imm = 3'd7;
      n.flushes = (m.flushes < cmax) ? m.flushes + 1 : m.flushes;
      n.squash_left = in.bt ? pen - 1 : m.squash_left - 1;
    end else if (mdl_hazard(m, in)) begin
      n.stalls = (m.stalls < cmax) ? m.stalls + 1 : m.stalls;
    end else begin
      n.inst = in.inst; n.pc = in.pc; n.valid = 1'b1; n.imm = mdl_imm(in.inst[6:0]);
    end
    return n;
  endfunction

  task automatic drive(input in_t in);
    rst = in.rst;
    bus_a.if_inst = in.inst; bus_a.if_pc = in.pc; bus_a.ex_mem_read = in.mr;
    bus_a.ex_rd = in.rd; bus_a.branch_taken = in.bt;
    bus_b.if_inst = in.inst; bus_b.if_pc = in.pc; bus_b.ex_mem_read = in.mr;
    bus_b.ex_rd = in.rd; bus_b.branch_taken = in.bt;
  endtask

  task automatic cycle_pre(input string tag, input in_t in);
    @(negedge clk);
    drive(in);
    #1;
    check({tag, " A pc_write"}, 32'(bus_a.pc_write), 32'(!mdl_hazard(ma, in) || in.bt));
    check({tag, " A bubble"}, 32'(bus_a.id_ex_bubble), 32'(mdl_hazard(ma, in) || !ma.valid));
    check({tag, " B pc_write"}, 32'(bus_b.pc_write), 32'(!mdl_hazard(mb, in) || in.bt));
    check({tag, " B bubble"}, 32'(bus_b.id_ex_bubble), 32'(mdl_hazard(mb, in) || !mb.valid));
  endtask

  task automatic cycle_post(input string tag, input in_t in);
    @(posedge clk);
    ma = mdl_step(ma, PEN_A, MAX_A, in);
    mb = mdl_step(mb, PEN_B, MAX_B, in);
    #1;
    check({tag, " A id_inst"}, bus_a.id_inst, ma.inst);
    check({tag, " A id_valid"}, 32'(bus_a.id_valid), 32'(ma.valid));
    check({tag, " A imm_type"}, 32'(bus_a.imm_type), 32'(ma.imm));
    check({tag, " A stall_cnt"}, 32'(stall_a), 32'(ma.stalls));
    check({tag, " A flush_cnt"}, 32'(flush_a), 32'(ma.flushes));
    if (ma.valid) check({tag, " A id_pc"}, bus_a.id_pc, ma.pc);
    check({tag, " B id_inst"}, bus_b.id_inst, mb.inst);
    check({tag, " B id_valid"}, 32'(bus_b.id_valid), 32'(mb.valid));
    check({tag, " B imm_type"}, 32'(bus_b.imm_type), 32'(mb.imm));
    check({tag, " B stall_cnt"}, 32'(stall_b), 32'(mb.stalls));
    check({tag, " B flush_cnt"}, 32'(flush_b), 32'(mb.flushes));
    if (mb.valid) check({tag, " B id_pc"}, bus_b.id_pc, mb.pc);
  endtask

  task automatic cycle(input string tag, input in_t in);
    cycle_pre(tag, in);
    cycle_post(tag, in);
  endtask

  function automatic in_t mk(input logic r, input logic [31:0] i, input logic [31:0] p,
                             input logic mr, input logic [4:0] rd, input logic bt);
    in_t x;
    x.rst = r; x.inst = i; x.pc = p; x.mr = mr; x.rd = rd; x.bt = bt;
    return x;
  endfunction

  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 9))
      0: return 7'b0110011;
      1: return 7'b0010011;
      2: return 7'b0000011;
      3: return 7'b0100011;
      4: return 7'b1100011;
      5: return 7'b1100111;
      6: return 7'b0110111;
      7: return 7'b0010111;
      8: return 7'b1101111;
      default: return 7'($urandom);
    endcase
  endfunction

  vec_t vecs[16];

  initial begin
    // Directed sequence on configuration A (BR_PENALTY=2), starting from reset.
    vecs[0]  = '{mk(0, 32'h00012083, 32'h100, 0, 0, 0), 1, 1, 32'h00012083, 32'h100, 1, 0, 0, 0};
    vecs[1]  = '{mk(0, 32'h00112223, 32'h104, 0, 0, 0), 1, 0, 32'h00112223, 32'h104, 1, 1, 0, 0};
    vecs[2]  = '{mk(0, 32'h004081B3, 32'h108, 0, 0, 0), 1, 0, 32'h004081B3, 32'h108, 1, 7, 0, 0};
    vecs[3]  = '{mk(0, 32'h00A00093, 32'h10C, 1, 1, 0), 0, 1, 32'h004081B3, 32'h108, 1, 7, 1, 0};
    vecs[4]  = '{mk(0, 32'h00A00093, 32'h10C, 1, 0, 0), 1, 0, 32'h00A00093, 32'h10C, 1, 0, 1, 0};
    vecs[5]  = '{mk(0, 32'h000010B7, 32'h110, 0, 0, 0), 1, 0, 32'h000010B7, 32'h110, 1, 3, 1, 0};
    vecs[6]  = '{mk(0, 32'h00000013, 32'h114, 1, 1, 0), 1, 0, 32'h00000013, 32'h114, 1, 0, 1, 0};
    vecs[7]  = '{mk(0, 32'h00C0006F, 32'h118, 0, 0, 1), 1, 0, NOP, 32'h0, 0, 7, 1, 1};
    vecs[8]  = '{mk(0, 32'h0000006F, 32'h200, 0, 0, 0), 1, 1, NOP, 32'h0, 0, 7, 1, 2};
    vecs[9]  = '{mk(0, 32'h0000006F, 32'h200, 0, 0, 0), 1, 1, 32'h0000006F, 32'h200, 1, 4, 1, 2};
    vecs[10] = '{mk(0, 32'h004081B3, 32'h204, 0, 0, 0), 1, 0, 32'h004081B3, 32'h204, 1, 7, 1, 2};
    vecs[11] = '{mk(0, 32'h0000006F, 32'h300, 1, 1, 1), 1, 1, NOP, 32'h0, 0, 7, 1, 3};
    vecs[12] = '{mk(0, 32'h0000006F, 32'h300, 0, 0, 1), 1, 1, NOP, 32'h0, 0, 7, 1, 4};
    vecs[13] = '{mk(0, 32'h0000006F, 32'h300, 0, 0, 0), 1, 1, NOP, 32'h0, 0, 7, 1, 5};
    vecs[14] = '{mk(0, 32'h00208463, 32'h300, 0, 0, 0), 1, 1, 32'h00208463, 32'h300, 1, 2, 1, 5};
    vecs[15] = '{mk(0, 32'h00000017, 32'h304, 0, 0, 0), 1, 0, 32'h00000017, 32'h304, 1, 3, 1, 5};

    ma = mdl_reset();
    mb = mdl_reset();
    drive(mk(1, 32'h00A00093, 32'h0, 0, 0, 0));

    cycle("reset0", mk(1, 32'h00A00093, 32'h0, 0, 0, 0));
    cycle("reset1", mk(1, 32'h00A00093, 32'h0, 0, 0, 0));
    check("reset id_inst", bus_a.id_inst, 32'h00000013);
    check("reset id_valid", 32'(bus_a.id_valid), 32'd0);
    check("reset imm_type", 32'(bus_a.imm_type), 32'd7);
    check("reset stall_cnt", 32'(stall_a), 32'd0);
    check("reset flush_cnt", 32'(flush_a), 32'd0);
    check("reset pc_write", 32'(bus_a.pc_write), 32'd1);

    for (int i = 0; i < 16; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      cycle_pre(t, vecs[i].in);
      check({t, " tbl pc_write"}, 32'(bus_a.pc_write), 32'(vecs[i].pcw));
      check({t, " tbl bubble"}, 32'(bus_a.id_ex_bubble), 32'(vecs[i].bub));
      cycle_post(t, vecs[i].in);
      check({t, " tbl id_inst"}, bus_a.id_inst, vecs[i].inst);
      check({t, " tbl id_valid"}, 32'(bus_a.id_valid), 32'(vecs[i].valid));
      check({t, " tbl imm_type"}, 32'(bus_a.imm_type), 32'(vecs[i].imm));
      check({t, " tbl stall_cnt"}, 32'(stall_a), 32'(vecs[i].stall));
      check({t, " tbl flush_cnt"}, 32'(flush_a), 32'(vecs[i].flush));
      if (vecs[i].valid) check({t, " tbl id_pc"}, bus_a.id_pc, vecs[i].pc);
    end

    // Held hazard for 20 cycles: the 4-bit counter must stop at 15.
    cycle("sat_rst", mk(1, NOP, 32'h0, 0, 0, 0));
    cycle("sat_ld", mk(0, 32'h004081B3, 32'h400, 0, 0, 0));
    for (int i = 0; i < 20; i++) cycle("sat", mk(0, NOP, 32'h404, 1, 1, 0));
    check("sat stall_cnt B", 32'(stall_b), 32'd15);
    check("sat stall_cnt A", 32'(stall_a), 32'd20);
    check("sat id_inst held", bus_a.id_inst, 32'h004081B3);

    // Reset in the middle of a squash window, then a normal load right after.
    cycle("midf_bt", mk(0, NOP, 32'h500, 0, 0, 1));
    cycle("midf_rst", mk(1, NOP, 32'h504, 0, 0, 0));
    check("midf stall_cnt", 32'(stall_a), 32'd0);
    check("midf flush_cnt", 32'(flush_a), 32'd0);
    check("midf flush_cnt B", 32'(flush_b), 32'd0);
    cycle("midf_ld", mk(0, 32'h00A00093, 32'h600, 0, 0, 0));
    check("midf run A valid", 32'(bus_a.id_valid), 32'd1);
    check("midf run B valid", 32'(bus_b.id_valid), 32'd1);
    check("midf run B inst", bus_b.id_inst, 32'h00A00093);

    for (int i = 0; i < 1500; i++) begin
      in_t x;
      logic [31:0] w;
      w = $urandom;
      w[6:0] = rand_op();
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      x = mk($urandom_range(0, 99) == 0, w, $urandom, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
      cycle($sformatf("rnd%0d", i), x);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_ctrl.md
Name: id_stage_ctrl

Overview:
- Owns the IF/ID pipeline register and sequences the decode stage of the pipelined RISC-V core.
- Detects load-use hazards and stalls PC and IF/ID for one cycle, with a bubble into ID/EX.
- Squashes wrong-path instructions after a taken branch for a parameterised number of cycles.
- Drives a registered immediate-format select for the decode-stage immediate generator.

Parameters:
- BR_PENALTY, 1, number of consecutive IF/ID loads squashed after branch_taken; legal range 1..7.
- CNT_W, 16, width of the saturating stall and flush event counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_inst  in  32  fetched instruction.
- if_pc  in  32  PC of if_inst.
- ex_mem_read  in  1  instruction in ID/EX is a load.
- ex_rd  in  5  destination register of the instruction in ID/EX.
- branch_taken  in  1  branch/jump resolved taken this cycle (redirect).
- id_inst  out  32  IF/ID instruction.
- id_pc  out  32  IF/ID PC.
- id_valid  out  1  IF/ID holds a live instruction.
- imm_type  out  3  immediate format of id_inst: 0 I, 1 S, 2 B, 3 U, 4 J, 7 none.
- pc_write  out  1  PC may advance (combinational).
- id_ex_bubble  out  1  zero the control fields entering ID/EX (combinational).
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  squashed IF/ID slots, saturating.

Behaviour:
- Reset (rst=1 at an edge):
  - id_inst=32'h00000013 (NOP), id_pc=0, id_valid=0, imm_type=7.
  - state=RUN, flush counter=0, stall_cnt=0, flush_cnt=0.
  - Reset overrides every other input, including mid-FLUSH or mid-stall.
- rs usage from id_inst opcode:
  - rs1 used by 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - rs2 used by 0110011, 0100011, 1100011.
- Hazard (combinational): id_valid & ex_mem_read & ex_rd!=0 & ((uses_rs1 & ex_rd==id_inst[19:15]) | (uses_rs2 & ex_rd==id_inst[24:20])).
- Outputs:
  - pc_write = !hazard | branch_taken.
  - id_ex_bubble = hazard | !id_valid.
- States: RUN, FLUSH; internal down-counter fcnt, 3 bits.
- Priority at each edge: rst > branch_taken > FLUSH squash > hazard hold > normal load.
- branch_taken=1 (either state):
  - id_inst=NOP, id_valid=0, imm_type=7; flush_cnt++.
  - If BR_PENALTY>1: state=FLUSH, fcnt=BR_PENALTY-1. Otherwise state=RUN.
  - A branch during FLUSH restarts the count.
- FLUSH without branch_taken:
  - id_inst=NOP, id_valid=0, imm_type=7; flush_cnt++; fcnt--.
  - When fcnt reaches 0 (i.e. was 1), state=RUN.
  - Hazard cannot occur in this state because id_valid=0.
- RUN with hazard:
  - IF/ID holds all fields unchanged; stall_cnt++.
  - A stall lasts exactly one cycle, because the bubble clears ex_mem_read next cycle; the block does not need to enforce this.
- RUN, no hazard:
  - id_inst=if_inst, id_pc=if_pc, id_valid=1.
  - imm_type is decoded from if_inst[6:0]:
    - 0000011/0010011/1100111 -> 0.
    - 0100011 -> 1.
    - 1100011 -> 2.
    - 0110111/0010111 -> 3.
    - 1101111 -> 4.
    - else 7 (R-type included).
- Counters saturate at all-ones and never wrap.
- Latency: if_inst appears on id_inst one cycle after capture.

Test Plan:
- Reset → assert rst 2 cycles with if_inst=32'h00A00093 → id_inst=32'h00000013, id_valid=0, imm_type=7, counters 0, pc_write=1.
- Normal flow → feed lw x1,0(x2) (32'h00012083) → next cycle id_inst=32'h00012083, id_valid=1, imm_type=0; then sw (32'h00112223) → imm_type=1.
- Load-use stall:
  - Stimulus: id_inst=add x3,x1,x4 (32'h004081B3), ex_mem_read=1, ex_rd=1.
  - Response: pc_write=0 and id_ex_bubble=1 that cycle; id_inst unchanged after the edge; stall_cnt=1.
  - Repeat with ex_rd=0 → no stall.
  - Repeat with a lui in IF/ID → no stall.
- Branch flush with BR_PENALTY=2 → branch_taken pulse 1 cycle → id_valid=0 for 2 edges, flush_cnt=2, then the target instruction loads with id_valid=1.
- Branch and hazard in the same cycle → flush wins: id_valid=0, stall_cnt unchanged, pc_write=1; a second branch mid-FLUSH restarts the count (3 squashed slots total with BR_PENALTY=2).
- Saturation and reset mid-operation:
  - Force CNT_W=4 and stall 20 cycles → stall_cnt=15.
  - Assert rst during FLUSH → next cycle state RUN, counters 0.
